featuremap_pad_fifo_writer: RTL and testbench

//  Producer end of the RGB feature-map FIFO that the conv2d filter blocks read (rdreq / data_fifo_empty).

---
 rtl/featuremap_pad_fifo_writer.sv | 110 +++++++++++
 tb/tb_featuremap_pad_fifo_writer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/featuremap_pad_fifo_writer.sv
`default_nettype none
// ============================================================================
//  featuremap_pad_fifo_writer
//  Streams a 1-pixel zero-padded {B,G,R} fp32 frame into the conv2d input FIFO.
//  Revision: 1.0
// ============================================================================
module featuremap_pad_fifo_writer #(
  parameter int                      DATA_WIDTH = 32,
  parameter int                      WIDTH      = 112,
  parameter int                      HEIGHT     = 112,
  parameter logic [DATA_WIDTH-1:0]   PAD_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH*3-1:0]   pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic                      fifo_full,
  output logic                      wrreq,
  output logic [DATA_WIDTH*3-1:0]   data_out,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int c_col_w = $clog2(WIDTH + 2);
  localparam int c_row_w = $clog2(HEIGHT + 2);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(WIDTH + 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(HEIGHT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_col_w-1:0]  r_col, w_col_nxt;
  logic [c_row_w-1:0]  r_row, w_row_nxt;

  logic w_run;
  logic w_border;
  logic w_write;

  assign w_run    = (r_state == S_RUN);
  assign w_border = (r_row == '0) || (r_row == c_row_last) ||
                    (r_col == '0) || (r_col == c_col_last);
  // Border words are synthesised locally, so only interior slots wait on the source.
  assign w_write  = w_run && !fifo_full && (w_border || pix_valid);

  assign wrreq      = w_write;
  assign pix_ready  = w_run && !fifo_full && !w_border;
  assign data_out   = w_border ? {3{PAD_VALUE}} : pix_in;
  assign busy       = w_run;
  assign frame_done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    case (r_state)
      S_IDLE: begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_write) begin
          if (r_col == c_col_last) begin
            w_col_nxt = '0;
            if (r_row == c_row_last) begin
              w_row_nxt   = '0;
              w_state_nxt = S_DONE;
            end else begin
              w_row_nxt = r_row + c_row_w'(1);
            end
          end else begin
            w_col_nxt = r_col + c_col_w'(1);
          end
        end
      end
      S_DONE: begin
        w_col_nxt   = '0;
        w_row_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_col_nxt   = '0;
        w_row_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_featuremap_pad_fifo_writer.sv
`default_nettype none
// Directed bench for featuremap_pad_fifo_writer: a 4x3 instance plus a default 112x112 instance.
module tb_featuremap_pad_fifo_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [95:0] pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        pix_ready, wrreq, busy, frame_done;
  logic [95:0] data_out;

  logic        big_start = 1'b0;
  logic        big_pix_ready, big_wrreq, big_busy, big_frame_done;
  logic [95:0] big_data_out;

  always #5 clk = ~clk;

  featuremap_pad_fifo_writer #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(3), .PAD_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .fifo_full(fifo_full), .wrreq(wrreq), .data_out(data_out),
    .busy(busy), .frame_done(frame_done)
  );

  featuremap_pad_fifo_writer big_dut (
    .clk(clk), .rst(rst), .start(big_start), .pix_in(96'h1), .pix_valid(1'b1),
    .pix_ready(big_pix_ready), .fifo_full(1'b0), .wrreq(big_wrreq), .data_out(big_data_out),
    .busy(big_busy), .frame_done(big_frame_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pix_idx = 1;
  int hs_cnt, done_cnt, done_cyc, stall_cycles, stall_viol;
  logic [95:0] wq[$];
  int          wr_cyc[$];
  bit          wr_pv[$];

  function automatic logic [31:0] fp32(input int n);
    case (n)
      1: return 32'h3F800000;  2: return 32'h40000000;  3: return 32'h40400000;
      4: return 32'h40800000;  5: return 32'h40A00000;  6: return 32'h40C00000;
      7: return 32'h40E00000;  8: return 32'h41000000;  9: return 32'h41100000;
      10: return 32'h41200000; 11: return 32'h41300000; 12: return 32'h41400000;
      default: return 32'hDEAD0000 | 32'(n);
    endcase
  endfunction

  function automatic logic [95:0] pixword(input int n);
    return {3{fp32(n)}};
  endfunction

  // Padded 6x5 raster: border -> +0.0, interior (r,c) -> pixel (r-1)*4 + c.
  function automatic logic [95:0] exp_word(input int w);
    int r, c;
    r = w / 6;
    c = w % 6;
    if (r == 0 || r == 4 || c == 0 || c == 5) return 96'h0;
    return pixword((r - 1) * 4 + c);
  endfunction

  task automatic cycle();
    bit hs;
    @(negedge clk);
    hs = pix_valid && pix_ready;
    if (wrreq) begin
      wq.push_back(data_out);
      wr_cyc.push_back(cyc);
      wr_pv.push_back(pix_valid);
    end
    if (fifo_full) begin
      stall_cycles++;
      if (wrreq || pix_ready) stall_viol++;
    end
    if (hs) hs_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs) pix_idx++;
    pix_in = pixword(pix_idx);
  endtask

  task automatic run_frame(input int stall_at, input bit sparse, input int rst_at,
                           input int start_at, input bit start_in_done, output bit timed_out);
    int  stall_left;
    bit  stall_used, busy_start_used, done_start_used, stopped;
    wq.delete(); wr_cyc.delete(); wr_pv.delete();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; stall_cycles = 0; stall_viol = 0;
    pix_idx = 1; pix_in = pixword(1);
    stall_left = 0; stall_used = 0; busy_start_used = 0; done_start_used = 0; stopped = 0;
    fifo_full = 1'b0; pix_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      pix_valid = sparse ? (n % 2 == 0) : 1'b1;
      fifo_full = (stall_left > 0);
      start = 1'b0;
      if (start_at >= 0 && wq.size() == start_at && !busy_start_used) begin
        start = 1'b1; busy_start_used = 1;
      end
      if (start_in_done && wq.size() == 30 && !done_start_used) begin
        start = 1'b1; done_start_used = 1;
      end
      cycle();
      if (fifo_full) stall_left--;
      if (stall_at >= 0 && wq.size() == stall_at && !stall_used) begin
        stall_left = 5; stall_used = 1;
      end
      if (rst_at >= 0 && wq.size() == rst_at) begin
        stopped = 1;
        break;
      end
      if (done_cnt > 0) begin
        stopped = 1;
        break;
      end
    end
    start = 1'b0; fifo_full = 1'b0; pix_valid = 1'b0;
    timed_out = !stopped;
  endtask

  task automatic test_reset();
    rst = 1'b0; pix_valid = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wrreq, pix_ready, busy, frame_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {wrreq, pix_ready, busy, frame_done});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({wrreq, pix_ready, busy} !== 3'b000) begin
      errors++; $display("FAIL idle_ignores_valid: got %b expected 000", {wrreq, pix_ready, busy});
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    int bad;
    run_frame(-1, 0, -1, -1, 0, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: no frame_done within budget"); end
    checks++;
    if (wq.size() != 30) begin errors++; $display("FAIL basic_writes: got %0d expected 30", wq.size()); end
    bad = 0;
    for (int i = 0; i < 30 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_word(i)) begin
        errors++; $display("FAIL basic_word%0d: got %h expected %h", i, wq[i], exp_word(i));
      end
    end
    checks++;
    if (hs_cnt != 12) begin errors++; $display("FAIL basic_handshakes: got %0d expected 12", hs_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    if (wq.size() == 30) begin
      checks++;
      if (done_cyc != wr_cyc[29] + 1) begin
        errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, wr_cyc[29] + 1);
      end
      checks++;
      if (wr_cyc[29] - wr_cyc[0] != 29) begin
        errors++; $display("FAIL basic_span: got %0d expected 29", wr_cyc[29] - wr_cyc[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_stall();
    bit to;
    run_frame(10, 0, -1, -1, 0, to);
    checks++;
    if (to || wq.size() != 30) begin
      errors++; $display("FAIL stall_writes: got %0d expected 30 (timeout=%0d)", wq.size(), to);
    end
    checks++;
    if (stall_cycles != 5 || stall_viol != 0) begin
      errors++; $display("FAIL stall_block: got %0d stall cycles with %0d strobes, expected 5 with 0", stall_cycles, stall_viol);
    end
    for (int i = 0; i < 30 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_word(i)) begin
        errors++; $display("FAIL stall_word%0d: got %h expected %h", i, wq[i], exp_word(i));
      end
    end
    if (wq.size() == 30) begin
      checks++;
      if (wr_cyc[29] - wr_cyc[0] != 34) begin
        errors++; $display("FAIL stall_span: got %0d expected 34", wr_cyc[29] - wr_cyc[0]);
      end
    end
    checks++;
    if (hs_cnt != 12) begin errors++; $display("FAIL stall_handshakes: got %0d expected 12", hs_cnt); end
  endtask

  task automatic test_sparse();
    bit to;
    run_frame(-1, 1, -1, -1, 0, to);
    checks++;
    if (to || wq.size() != 30) begin
      errors++; $display("FAIL sparse_writes: got %0d expected 30 (timeout=%0d)", wq.size(), to);
    end
    for (int i = 0; i < 30 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_word(i) || (exp_word(i) != 96'h0 && !wr_pv[i])) begin
        errors++; $display("FAIL sparse_word%0d: got %h valid=%0d expected %h", i, wq[i], wr_pv[i], exp_word(i));
      end
    end
    if (wq.size() == 30) begin
      checks++;
      if (wr_cyc[6] - wr_cyc[0] != 6) begin
        errors++; $display("FAIL sparse_border_b2b: got span %0d expected 6", wr_cyc[6] - wr_cyc[0]);
      end
    end
    checks++;
    if (hs_cnt != 12) begin errors++; $display("FAIL sparse_handshakes: got %0d expected 12", hs_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    run_frame(-1, 0, 15, -1, 0, to);
    checks++;
    if (to || wq.size() != 15) begin
      errors++; $display("FAIL midrst_reach: got %0d writes expected 15", wq.size());
    end
    pix_valid = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({wrreq, pix_ready, busy, frame_done} !== 4'b0000) begin
      errors++; $display("FAIL midrst_immediate: got %b expected 0000", {wrreq, pix_ready, busy, frame_done});
    end
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;
    run_frame(-1, 0, -1, -1, 0, to);
    checks++;
    if (to || wq.size() != 30) begin
      errors++; $display("FAIL midrst_refr_writes: got %0d expected 30", wq.size());
    end
    for (int i = 0; i < 30 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_word(i)) begin
        errors++; $display("FAIL midrst_word%0d: got %h expected %h", i, wq[i], exp_word(i));
      end
    end
  endtask

  task automatic test_start_busy();
    bit to;
    run_frame(-1, 0, -1, 8, 1, to);
    repeat (5) cycle();
    checks++;
    if (to || wq.size() != 30) begin
      errors++; $display("FAIL startbusy_writes: got %0d expected 30", wq.size());
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL startbusy_done: got %0d expected 1", done_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL startbusy_idle: got busy=%b expected 0", busy); end
    for (int i = 0; i < 30 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_word(i)) begin
        errors++; $display("FAIL startbusy_word%0d: got %h expected %h", i, wq[i], exp_word(i));
      end
    end
  endtask

  task automatic test_default_size();
    int writes = 0, hs = 0, first = -1, last = -1, dn = 0, bad = 0;
    big_start = 1'b1;
    @(posedge clk); #1;
    big_start = 1'b0;
    for (int n = 0; n < 14000; n++) begin
      @(negedge clk);
      if (big_wrreq) begin
        if (first < 0) first = n;
        last = n;
        // Border words must carry +0.0; interior words pass the source value through.
        if (big_pix_ready ? (big_data_out !== 96'h1) : (big_data_out !== 96'h0)) bad++;
        writes++;
      end
      if (big_pix_ready) hs++;
      if (big_frame_done) begin dn++; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (dn != 1) begin errors++; $display("FAIL default_done: got %0d expected 1", dn); end
    checks++;
    if (writes != 12996) begin errors++; $display("FAIL default_writes: got %0d expected 12996", writes); end
    checks++;
    if (hs != 12544) begin errors++; $display("FAIL default_handshakes: got %0d expected 12544", hs); end
    checks++;
    if (last - first + 1 != 12996) begin
      errors++; $display("FAIL default_span: got %0d expected 12996", last - first + 1);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL default_data: got %0d bad words expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_sparse();
    test_reset_mid();
    test_start_busy();
    test_default_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
